// File: rtl/serializer_pkg.sv
// Shared definitions for the bit serializer: FSM state type and default line level.
package serializer_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } ser_state_e;

    // Level driven on ser_out while no data bit is on the line.
    localparam logic IDLE_LEVEL_DEFAULT = 1'b0;

    // Width of the inter-word gap counter (GAP range 0..255).
    localparam int unsigned GAP_CNT_W = 8;

endpackage

// File: rtl/bit_serializer_shift_reg.sv
// WIDTH-bit load/shift register; presents the next bit to send on bit_o.
module bit_shift_reg #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             bit_o
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    // Load has priority; a shift moves the next bit toward the output end.
    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            sr_d = data_i;
        end else if (shift_i) begin
            if (MSB_FIRST) begin
                sr_d = {sr_q[WIDTH-2:0], 1'b0};
            end else begin
                sr_d = {1'b0, sr_q[WIDTH-1:1]};
            end
        end
    end

    // Shift register storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign bit_o = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with a one-word holding register and optional
// idle gap between words. Feeds the serial pattern detector's input.
module bit_serializer
    import serializer_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter int unsigned GAP        = 0,
    parameter logic        IDLE_LEVEL = IDLE_LEVEL_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_last,
    output logic             busy
);

    localparam int unsigned           CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]      LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [GAP_CNT_W-1:0]  GAP_LOAD = GAP_CNT_W'((GAP == 0) ? 0 : GAP - 1);

    ser_state_e             state_q, state_d;
    logic [WIDTH-1:0]       hold_q, hold_d;
    logic                   hold_full_q, hold_full_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [GAP_CNT_W-1:0]   gap_cnt_q, gap_cnt_d;

    logic accept;
    logic xfer;
    logic sh_load;
    logic sh_shift;
    logic sh_bit;

    assign accept = din_valid && !hold_full_q;

    // Next-state logic: holding register fill, FSM sequencing and counters.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        bit_cnt_d   = bit_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        xfer        = 1'b0;
        sh_shift    = 1'b0;

        if (accept) begin
            hold_d      = din;
            hold_full_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (hold_full_q) begin
                    xfer    = 1'b1;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (bit_cnt_q == LAST_BIT) begin
                    if (GAP != 0) begin
                        state_d   = S_GAP;
                        gap_cnt_d = GAP_LOAD;
                    end else if (hold_full_q) begin
                        xfer = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    sh_shift  = 1'b1;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == '0) begin
                    if (hold_full_q) begin
                        xfer    = 1'b1;
                        state_d = S_SHIFT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Accept needs hold empty and transfer needs hold full, so the two
        // hold_full_d updates can never collide on one edge.
        if (xfer) begin
            hold_full_d = 1'b0;
            bit_cnt_d   = '0;
        end
    end

    assign sh_load = xfer;

    // State, holding register and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
        end
    end

    bit_shift_reg #(
        .WIDTH    (WIDTH),
        .MSB_FIRST(MSB_FIRST)
    ) u_shift (
        .clk    (clk),
        .rst    (rst),
        .load_i (sh_load),
        .shift_i(sh_shift),
        .data_i (hold_q),
        .bit_o  (sh_bit)
    );

    assign din_ready  = !hold_full_q;
    assign ser_valid  = (state_q == S_SHIFT);
    assign ser_out    = ser_valid ? sh_bit : IDLE_LEVEL;
    assign frame_last = ser_valid && (bit_cnt_q == LAST_BIT);
    assign busy       = hold_full_q || (state_q != S_IDLE);

endmodule
